keypad_scan: RTL and testbench
==============================

// Module: keypad_scan
// PURPOSE
//   Drives and decodes the 4x4 matrix keypad: walks an active-low row strobe, samples
//   the active-low Col lines, debounces press and release, and emits one key event per
//   press. Feeds the calculator digit-entry logic, which consumes the number and Col values.
//   Key legend (row,col): r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: * 0 # D.
// PARAMETERS
//   SCAN_DIV      1000    clocks each row is driven before its Col sample is taken (>=4)
//   DEBOUNCE_CYC  50000   consecutive stable clocks required to accept a press or a release (>=2)
// PORTS
//   clk          in   1   system clock, all logic on posedge
//   rst_n        in   1   synchronous active-low reset
//   Col          in   4   keypad columns, active-low, asynchronous, 4'hF = no key
//   Row          out  4   keypad rows, active-low one-hot (row0 = 4'b1110)
//   key_code     out  4   code of last accepted key: 0-9 digits, A=10 B=11 C=12 D=13 *=14 #=15
//   number       out  32  key_code zero-extended to 32 bits
//   is_digit     out  1   1 when key_code <= 9
//   key_valid    out  1   one-cycle pulse when a press is accepted
//   key_pressed  out  1   level, 1 from acceptance of a press until its release is accepted
// BEHAVIOUR
//   - Col passes a 2-flop synchronizer (col_s); all decisions use col_s (2-cycle input latency).
//   - Reset (rst_n=0 at posedge): Row=4'b1110, row_idx=0, div=0, deb=0, state=SCAN,
//     key_code=0, number=0, is_digit=1, key_valid=0, key_pressed=0, synchronizer=4'hF.
//     Reset mid-press/mid-debounce aborts the operation; no event emitted.
//   - FSM states: SCAN, PRESS_DB, HELD, RELEASE_DB.
//   - SCAN: div counts 0..SCAN_DIV-1 with current Row driven. At div==SCAN_DIV-1:
//       col_s==4'hF -> row_idx advances (3 wraps to 0), Row updated, div=0.
//       else -> cand_col = lowest index with col_s bit low, cand_row = row_idx, deb=0,
//       go PRESS_DB; Row frozen.
//   - PRESS_DB: Row frozen. col_s[cand_col]==0 -> deb++; col_s[cand_col]==1 -> div=0,
//     back to SCAN on same row, no event. When deb reaches DEBOUNCE_CYC-1 with the
//     column still low: next cycle key_code/number/is_digit load decoded key, key_valid=1
//     for exactly that cycle, key_pressed=1, go HELD.
//   - HELD: Row frozen, no further key_valid regardless of hold time (no auto-repeat).
//     col_s[cand_col]==1 -> deb=0, go RELEASE_DB.
//   - RELEASE_DB: col_s[cand_col]==1 -> deb++; col_s[cand_col]==0 -> back to HELD.
//     When deb reaches DEBOUNCE_CYC-1: key_pressed=0, row_idx advances, div=0, go SCAN.
//   - Multiple keys: lowest column in the first row found wins; other keys ignored
//     until release is accepted. Changes on other columns during HELD are ignored.
//   - key_code/number/is_digit hold last accepted key until next acceptance or reset.
//   - Idle keypad: each row driven SCAN_DIV clocks; full sweep = 4*SCAN_DIV clocks.
//   - Counters sized to $clog2 of their parameter; no wrap beyond terminal values.
// TESTING  (bench uses SCAN_DIV=4, DEBOUNCE_CYC=8; keypad model grounds Col[c] when Row[r]=0)
//   1 Reset, no key -> Row cycles 1110,1101,1011,0111,1110 every 4 clks; key_valid never 1.
//   2 Hold '5' (r1,c1) 100 clks -> exactly one key_valid pulse, key_code=5, number=32'd5,
//     is_digit=1, key_pressed=1 while held; release -> key_pressed=0 after 8 stable clks + sync.
//   3 '5' low for 3 clks then released (bounce) -> no key_valid, scan resumes on row1.
//   4 Release glitch: in HELD drop key for 4 clks then re-press -> key_pressed stays 1, no new pulse.
//   5 '*' and '#' held together (r3,c0 and c2) -> key_code=14, number=32'd14, is_digit=0.
//   6 rst_n=0 during HELD of 'D' -> next cycle all outputs at reset values; after rst_n=1
//     with 'D' still held -> new pulse key_code=13 after scan + debounce.

Source files
------------

// File: rtl/keypad_scan_if.sv
// keypad_scan_if: keypad matrix lines plus decoded key outputs.
//   Col         keypad columns, active-low (driven by the keypad side)
//   Row         keypad rows, active-low one-hot strobe (driven by the scanner)
//   key_code    code of last accepted key
//   number      key_code zero-extended to 32 bits
//   is_digit    1 when key_code is 0-9
//   key_valid   one-cycle pulse per accepted press
//   key_pressed level, high from press acceptance until release acceptance
interface keypad_scan_if;
    logic [3:0]  Col;
    logic [3:0]  Row;
    logic [3:0]  key_code;
    logic [31:0] number;
    logic        is_digit;
    logic        key_valid;
    logic        key_pressed;

    modport master (
        output Col,
        input  Row, key_code, number, is_digit, key_valid, key_pressed
    );

    modport slave (
        input  Col,
        output Row, key_code, number, is_digit, key_valid, key_pressed
    );
endinterface

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix keypad scanner with press/release debounce and one event per press.
//   clk    system clock, posedge
//   rst_n  synchronous active-low reset
//   kp     keypad_scan_if.slave: Col in, Row/key_code/number/is_digit/key_valid/key_pressed out
module keypad_scan #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CYC = 50000
) (
    input  logic          clk,
    input  logic          rst_n,
    keypad_scan_if.slave  kp
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(DEBOUNCE_CYC);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DEB_LAST = BW'(DEBOUNCE_CYC - 1);
    // Nibble {row,col} holds the key code: r0 1 2 3 A, r1 4 5 6 B, r2 7 8 9 C, r3 * 0 # D
    localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

    typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, RELEASE_DB} state_t;

    state_t        state_q;
    logic [3:0]    col_s1_q;
    logic [3:0]    col_s_q;
    logic [1:0]    row_idx_q;
    logic [1:0]    cand_col_q;
    logic [DW-1:0] div_q;
    logic [BW-1:0] deb_q;
    logic [3:0]    key_code_q;
    logic          key_valid_q;
    logic          key_pressed_q;
    logic [1:0]    first_low;
    logic          cand_low;

    // Lowest-index column that is pulled low wins
    assign first_low = !col_s_q[0] ? 2'd0 : !col_s_q[1] ? 2'd1 : !col_s_q[2] ? 2'd2 : 2'd3;
    assign cand_low  = !col_s_q[cand_col_q];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= SCAN;
            col_s1_q      <= 4'hF;
            col_s_q       <= 4'hF;
            row_idx_q     <= '0;
            cand_col_q    <= '0;
            div_q         <= '0;
            deb_q         <= '0;
            key_code_q    <= '0;
            key_valid_q   <= 1'b0;
            key_pressed_q <= 1'b0;
        end else begin
            col_s1_q    <= kp.Col;
            col_s_q     <= col_s1_q;
            key_valid_q <= 1'b0;
            case (state_q)
                SCAN: begin
                    if (div_q != DIV_LAST) begin
                        div_q <= div_q + 1'b1;
                    end else if (col_s_q == 4'hF) begin
                        row_idx_q <= row_idx_q + 1'b1;
                        div_q     <= '0;
                    end else begin
                        // Row stays frozen on row_idx_q until the key is released
                        cand_col_q <= first_low;
                        deb_q      <= '0;
                        state_q    <= PRESS_DB;
                    end
                end
                PRESS_DB: begin
                    if (!cand_low) begin
                        div_q   <= '0;
                        state_q <= SCAN;
                    end else if (deb_q == DEB_LAST) begin
                        key_code_q    <= KEY_MAP[{row_idx_q, cand_col_q, 2'b00} +: 4];
                        key_valid_q   <= 1'b1;
                        key_pressed_q <= 1'b1;
                        state_q       <= HELD;
                    end else begin
                        deb_q <= deb_q + 1'b1;
                    end
                end
                HELD: begin
                    if (!cand_low) begin
                        deb_q   <= '0;
                        state_q <= RELEASE_DB;
                    end
                end
                RELEASE_DB: begin
                    if (cand_low) begin
                        state_q <= HELD;
                    end else if (deb_q == DEB_LAST) begin
                        key_pressed_q <= 1'b0;
                        row_idx_q     <= row_idx_q + 1'b1;
                        div_q         <= '0;
                        state_q       <= SCAN;
                    end else begin
                        deb_q <= deb_q + 1'b1;
                    end
                end
                default: state_q <= SCAN;
            endcase
        end
    end

    assign kp.Row         = ~(4'b0001 << row_idx_q);
    assign kp.key_code    = key_code_q;
    assign kp.number      = {28'b0, key_code_q};
    assign kp.is_digit    = key_code_q <= 4'd9;
    assign kp.key_valid   = key_valid_q;
    assign kp.key_pressed = key_pressed_q;
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: randomized keypad presses checked against a timing/legend reference model.
module tb_keypad_scan;
    localparam int SD = 4;
    localparam int DB = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] keys = '0;
    logic [3:0]  col_m;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          pulses = 0;
    int          pulse_cyc = -1;
    int          rise_cyc = -1;
    int          fall_cyc = -1;
    logic [3:0]  pulse_code = '0;
    logic [31:0] pulse_num = '0;
    logic        pulse_dig = 1'b0;
    logic        kp_prev = 1'b0;
    string       legend = "123A456B789C*0#D";

    keypad_scan_if kp ();

    keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_CYC(DB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kp    (kp.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Keypad matrix: a pressed key grounds its column while its row is driven low
    always_comb begin
        col_m = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && kp.Row[r] === 1'b0) col_m[c] = 1'b0;
    end
    assign kp.Col = col_m;

    always @(negedge clk) begin
        if (kp.key_valid === 1'b1) begin
            pulses++;
            pulse_cyc  = cyc;
            pulse_code = kp.key_code;
            pulse_num  = kp.number;
            pulse_dig  = kp.is_digit;
        end
        if (kp.key_pressed === 1'b1 && !kp_prev) rise_cyc = cyc;
        if (kp.key_pressed === 1'b0 && kp_prev) fall_cyc = cyc;
        kp_prev = kp.key_pressed === 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] row_of(input int r);
        logic [3:0] one = 4'b0001;
        return ~(one << r);
    endfunction

    function automatic logic [3:0] code_of(input byte ch);
        if (ch >= "0" && ch <= "9") return 4'(ch - 8'd48);
        if (ch >= "A" && ch <= "D") return 4'(ch - 8'd55);
        return ch == "*" ? 4'd14 : 4'd15;
    endfunction

    // Waits for Row to switch into the given row pattern (start of its scan window)
    task automatic wait_row(input logic [3:0] target);
        logic [3:0] prev = kp.Row;
        logic       found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            tick(1);
            found = kp.Row == target && prev != target;
            prev  = kp.Row;
        end
        chk("row_wait", {31'b0, found}, 32'd1);
    endtask

    // Press keys in row r at the start of that row's window for n clocks, then release.
    // Column low through sync + remaining window + debounce: accepted iff n >= SD+DB-2,
    // pulse SD+DB clocks after the window opens, release accepted DB+3 clocks after letting go.
    task automatic press(input logic [15:0] mask, input int r, input int n);
        int   win = -1;
        int   t0, r0, p0;
        byte  ch;
        for (int c = 0; c < 4; c++) if (win < 0 && mask[r*4+c]) win = c;
        wait_row(row_of(r));
        t0 = cyc;
        p0 = pulses;
        keys = mask;
        tick(n);
        if (win >= 0 && n > SD + DB) chk("held_level", {31'b0, kp.key_pressed}, 32'd1);
        keys = '0;
        r0 = cyc;
        if (win >= 0 && n >= SD + DB - 2) begin
            ch = legend[r*4+win];
            tick(DB + 6);
            chk("pulse_count", pulses - p0, 32'd1);
            chk("pulse_time", pulse_cyc, t0 + SD + DB);
            chk("key_code", {28'b0, pulse_code}, {28'b0, code_of(ch)});
            chk("number", pulse_num, {28'b0, code_of(ch)});
            chk("is_digit", {31'b0, pulse_dig}, {31'b0, ch >= "0" && ch <= "9"});
            chk("press_rise", rise_cyc, pulse_cyc);
            chk("release_time", fall_cyc, r0 + DB + 3);
        end else begin
            for (int i = 0; i < 40 && kp.Row == row_of(r); i++) tick(1);
            chk("resume_row", {28'b0, kp.Row}, {28'b0, row_of((r + 1) % 4)});
            tick(DB);
            chk("no_pulse", pulses - p0, 32'd0);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_row"}, {28'b0, kp.Row}, 32'hE);
        chk({tag, "_code"}, {28'b0, kp.key_code}, 32'd0);
        chk({tag, "_number"}, kp.number, 32'd0);
        chk({tag, "_digit"}, {31'b0, kp.is_digit}, 32'd1);
        chk({tag, "_valid"}, {31'b0, kp.key_valid}, 32'd0);
        chk({tag, "_pressed"}, {31'b0, kp.key_pressed}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation bound exceeded");
        $fatal(1);
    end

    initial begin
        int p0, r, c, n;
        logic found;
        tick(3);
        check_reset_state("reset");
        rst_n = 1'b1;

        // Idle sweep: each row held SD clocks, wrapping after row3
        wait_row(4'b1101);
        for (int k = 0; k < 5; k++) begin
            chk("idle_row", {28'b0, kp.Row}, {28'b0, row_of((1 + k) % 4)});
            tick(SD);
        end
        chk("idle_no_pulse", pulses, 32'd0);

        press(16'h0020, 1, 100);
        press(16'h0020, 1, 3);
        press(16'h0020, 1, SD + DB - 3);
        press(16'h0020, 1, SD + DB - 2);
        press(16'h5000, 3, 30);

        // Release glitch shorter than the debounce keeps the key held without a new event
        wait_row(row_of(1));
        p0 = pulses;
        keys = 16'h0020;
        tick(20);
        keys = '0;
        tick(4);
        keys = 16'h0020;
        tick(20);
        chk("glitch_held", {31'b0, kp.key_pressed}, 32'd1);
        chk("glitch_pulses", pulses - p0, 32'd1);
        keys = '0;
        n = cyc;
        tick(DB + 6);
        chk("glitch_release", fall_cyc, n + DB + 3);

        // Reset while 'D' is held, then a fresh event once scanning reaches row3 again
        wait_row(row_of(3));
        keys = 16'h8000;
        tick(20);
        chk("d_held", {31'b0, kp.key_pressed}, 32'd1);
        rst_n = 1'b0;
        tick(1);
        check_reset_state("midrst");
        rst_n = 1'b1;
        p0 = pulses;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick(1);
            found = pulses > p0;
        end
        chk("d_repulse", {31'b0, found}, 32'd1);
        chk("d_code", {28'b0, pulse_code}, 32'd13);
        keys = '0;
        tick(DB + 6);

        for (int i = 0; i < 14; i++) begin
            r = $urandom_range(0, 3);
            c = $urandom_range(0, 3);
            n = $urandom_range(3, 30);
            press(16'h0001 << (r * 4 + c), r, n);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
